// File: rtl/leaf_interface.sv
// rtl/leaf_interface.sv - tree-network leaf: client TX/RX FIFOs plus deflection reinjection
// Optional feature macro: LEAF_DROP_CNT_EN adds a saturating RX drop counter output.

module leaf_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO only lands when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign rdata = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr[aw-1:0]] <= wdata;
    end
endmodule

module leaf_interface #(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int addr       = 0,
    parameter int fifo_depth = 4,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_sz-1:0]               bus_i,
    output logic [p_sz-1:0]               bus_o,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(num_leaves)-1:0] in_addr,
    input  logic [payload_sz-1:0]         in_payload,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef LEAF_DROP_CNT_EN
    output logic [15:0]                   drop_cnt,
`endif
    output logic [payload_sz-1:0]         out_payload
);
    localparam int aw = $clog2(num_leaves);
    localparam logic [aw-1:0] own_addr = aw'(addr);

    logic            bus_valid;
    logic [aw-1:0]   bus_dest;
    logic            is_local;
    logic            is_deflected;

    logic            tx_push;
    logic            tx_pop;
    logic [p_sz-2:0] tx_head;
    logic            tx_full;
    logic            tx_empty;

    logic            rx_pop;
    logic            rx_full;
    logic            rx_empty;

    logic            reinj_valid;
    logic [p_sz-1:0] reinj_pkt;

    assign bus_valid    = bus_i[p_sz-1];
    assign bus_dest     = bus_i[p_sz-2:payload_sz];
    assign is_local     = bus_valid && (bus_dest == own_addr);
    assign is_deflected = bus_valid && (bus_dest != own_addr);

    assign in_ready  = !tx_full;
    assign tx_push   = in_valid && in_ready;
    // A pending reinjection owns the output slot, so the TX head waits.
    assign tx_pop    = !reinj_valid && !tx_empty;

    assign out_valid = !rx_empty;
    assign rx_pop    = out_valid && out_ready;

    leaf_fifo #(.width(p_sz-1), .depth(fifo_depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata ({in_addr, in_payload}),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    leaf_fifo #(.width(payload_sz), .depth(fifo_depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (is_local),
        .pop   (rx_pop),
        .wdata (bus_i[payload_sz-1:0]),
        .rdata (out_payload),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // The reinject slot is emptied every edge, so it can take a new deflection each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            reinj_valid <= 1'b0;
            reinj_pkt   <= '0;
        end else begin
            reinj_valid <= is_deflected;
            reinj_pkt   <= bus_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)            bus_o <= '0;
        else if (reinj_valid) bus_o <= reinj_pkt;
        else if (!tx_empty)   bus_o <= {1'b1, tx_head};
        else                  bus_o <= '0;
    end

`ifdef LEAF_DROP_CNT_EN
    logic rx_drop;
    assign rx_drop = is_local && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (reset)                                 drop_cnt <= 16'd0;
        else if (rx_drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_leaf_interface.sv
// tb/tb_leaf_interface.sv - randomized self-checking bench for leaf_interface with a queue-based model

module tb_leaf_interface;
    localparam int LEAVES = 4;
    localparam int PW     = 4;
    localparam int MY     = 1;
    localparam int DEPTH  = 4;
    localparam int PSZ    = 1 + 2 + PW;

    logic           clk = 1'b0;
    logic           reset;
    logic [PSZ-1:0] bus_i;
    logic [PSZ-1:0] bus_o;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_addr;
    logic [PW-1:0]  in_payload;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  out_payload;
`ifdef LEAF_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // behavioural model state
    logic [PSZ-2:0] tx_q[$];
    logic [PW-1:0]  rx_q[$];
    logic           m_rv;
    logic [PSZ-1:0] m_rp;
    logic [PSZ-1:0] m_bus;
    int             m_drops;

    leaf_interface #(
        .num_leaves (LEAVES),
        .payload_sz (PW),
        .addr       (MY),
        .fifo_depth (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_i       (bus_i),
        .bus_o       (bus_o),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef LEAF_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .out_payload (out_payload)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic [PSZ-1:0] nb;
        int tx_n;
        int rx_n;
        logic pop;
        if (reset) begin
            tx_q.delete();
            rx_q.delete();
            m_rv = 1'b0;
            m_rp = '0;
            m_bus = '0;
            m_drops = 0;
        end else begin
            tx_n = tx_q.size();
            rx_n = rx_q.size();
            pop  = (rx_n > 0) && out_ready;
            if (m_rv)          nb = m_rp;
            else if (tx_n > 0) nb = {1'b1, tx_q.pop_front()};
            else               nb = '0;
            if (in_valid && tx_n < DEPTH) tx_q.push_back({in_addr, in_payload});
            if (pop) void'(rx_q.pop_front());
            if (bus_i[PSZ-1] && bus_i[PSZ-2:PW] == 2'(MY)) begin
                if (rx_n < DEPTH || pop) rx_q.push_back(bus_i[PW-1:0]);
                else if (m_drops < 65535) m_drops++;
            end
            m_rv  = bus_i[PSZ-1] && bus_i[PSZ-2:PW] != 2'(MY);
            m_rp  = bus_i;
            m_bus = nb;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_payload = '0;
        bus_i = '0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; in_valid = 1'b1; bus_i = {1'b1, 2'd1, 4'h5};
        tick();
        idle();
        checks++; if (bus_o !== '0) begin fails++; $display("FAIL reset_bus_o got %h want 0", bus_o); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || bus_o !== '0) begin fails++; $display("FAIL reset_ignored got ov=%b bus=%h want 0 0", out_valid, bus_o); end
    endtask

    task automatic test_tx_latency();
        logic [PW-1:0] pl;
        pl = PW'($urandom);
        idle();
        in_valid = 1'b1; in_addr = 2'd2; in_payload = pl;
        tick();
        idle();
        checks++; if (bus_o !== '0) begin fails++; $display("FAIL tx_edge0 got %h want 0", bus_o); end
        tick();
        checks++; if (bus_o !== {1'b1, 2'd2, pl} || bus_o !== m_bus) begin fails++; $display("FAIL tx_edge1 got %h want %h", bus_o, {1'b1, 2'd2, pl}); end
        tick();
        checks++; if (bus_o !== '0) begin fails++; $display("FAIL tx_edge2 got %h want 0", bus_o); end
    endtask

    task automatic test_rx_pulse();
        logic [PW-1:0] pl;
        pl = PW'($urandom);
        idle();
        bus_i = {1'b1, 2'd1, pl}; out_ready = 1'b1;
        tick();
        bus_i = '0;
        checks++; if (out_valid !== 1'b1 || out_payload !== pl) begin fails++; $display("FAIL rx_pulse got ov=%b pl=%h want 1 %h", out_valid, out_payload, pl); end
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rx_pulse_end got %b want 0", out_valid); end
        idle();
    endtask

    task automatic test_deflect();
        logic [PW-1:0] p1, p2;
        p1 = PW'($urandom); p2 = PW'($urandom);
        idle();
        in_valid = 1'b1; in_addr = 2'd0; in_payload = p1;
        bus_i = {1'b1, 2'd3, p2};
        tick();
        idle();
        checks++; if (bus_o !== '0) begin fails++; $display("FAIL deflect_e0 got %h want 0", bus_o); end
        tick();
        checks++; if (bus_o !== {1'b1, 2'd3, p2}) begin fails++; $display("FAIL deflect_first got %h want %h", bus_o, {1'b1, 2'd3, p2}); end
        tick();
        checks++; if (bus_o !== {1'b1, 2'd0, p1}) begin fails++; $display("FAIL deflect_tx_next got %h want %h", bus_o, {1'b1, 2'd0, p1}); end
        tick();
        checks++; if (bus_o !== '0) begin fails++; $display("FAIL deflect_after got %h want 0", bus_o); end
    endtask

    task automatic test_rx_overflow();
        logic [PW-1:0] pl[5];
        logic [PW-1:0] extra;
        idle();
        for (int i = 0; i < 5; i++) begin
            pl[i] = PW'($urandom);
            bus_i = {1'b1, 2'd1, pl[i]};
            tick();
        end
        bus_i = '0;
        checks++; if (out_valid !== 1'b1 || out_payload !== pl[0]) begin fails++; $display("FAIL ovf_head got ov=%b pl=%h want 1 %h", out_valid, out_payload, pl[0]); end
        checks++; if (rx_q.size() != 4 || m_drops != 1) begin fails++; $display("FAIL ovf_model got size=%0d drops=%0d want 4 1", rx_q.size(), m_drops); end
`ifdef LEAF_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
`endif
        // full FIFO with simultaneous pop and push keeps both
        extra = PW'($urandom);
        out_ready = 1'b1; bus_i = {1'b1, 2'd1, extra};
        tick();
        bus_i = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_payload !== (i < 3 ? pl[i+1] : extra)) begin
                fails++; $display("FAIL ovf_drain%0d got ov=%b pl=%h want 1 %h", i, out_valid, out_payload, (i < 3 ? pl[i+1] : extra));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b want 0", out_valid); end
`ifdef LEAF_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL ovf_drop_cnt2 got %0d want 1", drop_cnt); end
`endif
        idle();
    endtask

    task automatic test_backpressure();
        int accepts;
        idle();
        accepts = 0;
        in_valid = 1'b1; in_addr = 2'd2;
        bus_i = {1'b1, 2'd0, 4'hA};
        for (int i = 0; i < 8; i++) begin
            in_payload = PW'(i);
            if (in_ready) accepts++;
            tick();
        end
        checks++; if (accepts != 4 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_accepts got %0d ready=%b want 4 0", accepts, in_ready); end
        idle();
        tick();
        checks++; if (in_ready !== 1'b0 || bus_o !== {1'b1, 2'd0, 4'hA}) begin fails++; $display("FAIL bp_reinj got ready=%b bus=%h want 0 %h", in_ready, bus_o, {1'b1, 2'd0, 4'hA}); end
        tick();
        checks++; if (in_ready !== 1'b1 || bus_o !== {1'b1, 2'd2, 4'h0}) begin fails++; $display("FAIL bp_pop got ready=%b bus=%h want 1 %h", in_ready, bus_o, {1'b1, 2'd2, 4'h0}); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bus_o !== '0) begin fails++; $display("FAIL bp_drained got %h want 0", bus_o); end
    endtask

    task automatic test_reset_mid();
        idle();
        bus_i = {1'b1, 2'd3, 4'h7}; in_valid = 1'b1; in_addr = 2'd0; in_payload = 4'h3;
        tick(); tick();
        in_valid = 1'b0; bus_i = {1'b1, 2'd1, 4'h9};
        tick(); tick();
        reset = 1'b1; bus_i = {1'b1, 2'd1, 4'hC}; in_valid = 1'b1;
        tick();
        idle();
        checks++; if (bus_o !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset got bus=%h ov=%b ir=%b want 0 0 1", bus_o, out_valid, in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus_o !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale%0d got bus=%h ov=%b want 0 0", i, bus_o, out_valid); end
        end
    endtask

    task automatic test_random();
        idle();
        reset = 1'b1; tick();
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            in_valid   = $urandom_range(0, 1);
            in_addr    = 2'($urandom);
            in_payload = PW'($urandom);
            bus_i      = ($urandom_range(0, 2) != 0) ? {1'b1, 2'($urandom_range(0, 2) == 0 ? 2'($urandom) : 2'd1), PW'($urandom)} : '0;
            out_ready  = ($urandom_range(0, 3) == 0);
            tick();
            checks++; if (bus_o !== m_bus) begin fails++; $display("FAIL rnd_bus_o cyc %0d got %h want %h", n, bus_o, m_bus); end
            checks++; if (in_ready !== (tx_q.size() < DEPTH)) begin fails++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", n, in_ready, tx_q.size() < DEPTH); end
            checks++; if (out_valid !== (rx_q.size() > 0)) begin fails++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", n, out_valid, rx_q.size() > 0); end
            if (rx_q.size() > 0) begin
                checks++; if (out_payload !== rx_q[0]) begin fails++; $display("FAIL rnd_payload cyc %0d got %h want %h", n, out_payload, rx_q[0]); end
            end
`ifdef LEAF_DROP_CNT_EN
            checks++; if (drop_cnt !== 16'(m_drops)) begin fails++; $display("FAIL rnd_drop_cnt cyc %0d got %0d want %0d", n, drop_cnt, m_drops); end
`endif
        end
        idle();
    endtask

    initial begin
        m_rv = 1'b0; m_rp = '0; m_bus = '0; m_drops = 0;
        idle();
        test_reset();
        test_tx_latency();
        test_rx_pulse();
        test_deflect();
        test_rx_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule
